// File: rtl/fp_int_operand_feeder.sv
// Operand feeder for the FP16 x int multiplier: unpacks one weight lane per
// activation and presents registered (activation, weight) pairs downstream.
module fp_int_operand_feeder #(
  parameter int WIDTH_A    = 16,
  parameter int INT_WIDTH  = 4,
  parameter int WORD_WIDTH = 32,
  parameter int LANES      = WORD_WIDTH / INT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [WORD_WIDTH-1:0] weight_word_i,
  input  logic                  weight_valid_i,
  output logic                  weight_ready_o,
  input  logic [WIDTH_A-1:0]    act_i,
  input  logic                  act_valid_i,
  output logic                  act_ready_o,
  output logic [WIDTH_A-1:0]    operand_a_o,
  output logic [INT_WIDTH-1:0]  operand_b_o,
  output logic                  last_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic {EMPTY, LOADED} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [WIDTH_A-1:0]    op_a_q, op_a_d;
  logic [INT_WIDTH-1:0]  op_b_q, op_b_d;
  logic                  last_q, last_d;
  logic                  out_valid_q, out_valid_d;

  logic loaded;
  logic can_issue;
  logic fire;
  logic last_lane;
  logic word_accept;

  // Readies are gated by rst_ni so nothing is consumed while reset is held.
  assign loaded      = rst_ni && (state_q == LOADED);
  assign can_issue   = !out_valid_q || out_ready_i;
  assign fire        = loaded && act_valid_i && can_issue;
  assign last_lane   = (idx_q == LAST_IDX);
  assign word_accept = weight_valid_i && weight_ready_o;

  assign act_ready_o    = loaded && can_issue;
  assign weight_ready_o = rst_ni && ((state_q == EMPTY) || (last_lane && fire));

  assign operand_a_o = op_a_q;
  assign operand_b_o = op_b_q;
  assign last_o      = last_q;
  assign out_valid_o = out_valid_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;

    if (fire) begin
      op_a_d      = act_i;
      op_b_d      = word_q[idx_q*INT_WIDTH +: INT_WIDTH];
      last_d      = last_lane;
      out_valid_d = 1'b1;
      if (!last_lane) begin
        idx_d = idx_q + 1'b1;
      end else begin
        state_d = EMPTY;
        idx_d   = '0;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end

    // A refill on the last-lane fire overrides the drop back to EMPTY.
    if (word_accept) begin
      word_d  = weight_word_i;
      idx_d   = '0;
      state_d = LOADED;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      idx_q       <= '0;
      word_q      <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fp_int_operand_feeder.sv
// Self-checking bench for fp_int_operand_feeder: directed scenarios plus
// randomized handshakes scored against a queue-based pairing model.
module tb_fp_int_operand_feeder;

  logic        clk;
  logic        rst_ni;
  logic [31:0] weight_word_i;
  logic        weight_valid_i;
  logic        weight_ready_o;
  logic [15:0] act_i;
  logic        act_valid_i;
  logic        act_ready_o;
  logic [15:0] operand_a_o;
  logic [3:0]  operand_b_o;
  logic        last_o;
  logic        out_valid_o;
  logic        out_ready_i;

  fp_int_operand_feeder dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .weight_word_i  (weight_word_i),
    .weight_valid_i (weight_valid_i),
    .weight_ready_o (weight_ready_o),
    .act_i          (act_i),
    .act_valid_i    (act_valid_i),
    .act_ready_o    (act_ready_o),
    .operand_a_o    (operand_a_o),
    .operand_b_o    (operand_b_o),
    .last_o         (last_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;

  logic        dRst = 1'b0;
  logic        dWv = 1'b0;
  logic [31:0] dWord = '0;
  logic        dAv = 1'b0;
  logic [15:0] dAct = '0;
  logic        dOrdy = 1'b0;

  logic [31:0] wordQ[$];
  logic [15:0] actQ[$];
  int          outCnt = 0;

  logic [31:0] srcW[$];
  logic [15:0] srcA[$];
  logic [3:0]  outBs[$];
  int          outCycles[$];

  int          cycleNo = 0;
  int          wordHsCycle = 0;
  logic        lastWHs = 1'b0;
  logic        lastAHs = 1'b0;
  logic        sAr = 1'b0;
  logic        sWr = 1'b0;
  logic        justReset = 1'b0;
  logic        prevHold = 1'b0;
  logic [15:0] prevA = '0;
  logic [3:0]  prevB = '0;
  logic        prevLast = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycleNo);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 time unit before posedge.
  task automatic applyStimulus();
    int          remaining;
    int          outstanding;
    int          k;
    logic        expOv;
    logic        expAr;
    logic        expWr;
    logic        wHs;
    logic        aHs;
    logic        oHs;
    logic [31:0] w;
    @(negedge clk);
    rst_ni         = dRst;
    weight_valid_i = dWv;
    weight_word_i  = dWord;
    act_valid_i    = dAv;
    act_i          = dAct;
    out_ready_i    = dOrdy;
    #4;
    sAr = act_ready_o;
    sWr = weight_ready_o;
    wHs = 1'b0;
    aHs = 1'b0;
    oHs = 1'b0;
    if (!dRst) begin
      checkOutput("rst_wready", {31'b0, weight_ready_o}, 32'd0);
      checkOutput("rst_aready", {31'b0, act_ready_o}, 32'd0);
      prevHold = 1'b0;
    end else begin
      remaining   = 8 * wordQ.size() - actQ.size();
      outstanding = actQ.size() - outCnt;
      expOv = (outstanding != 0);
      expAr = (remaining > 0) && (!expOv || dOrdy);
      expWr = (remaining == 0) || (remaining == 1 && dAv && expAr);
      checkOutput("out_valid", {31'b0, out_valid_o}, {31'b0, expOv});
      checkOutput("act_ready", {31'b0, act_ready_o}, {31'b0, expAr});
      checkOutput("weight_ready", {31'b0, weight_ready_o}, {31'b0, expWr});
      if (justReset) begin
        checkOutput("post_rst_a", {16'b0, operand_a_o}, 32'd0);
        checkOutput("post_rst_b", {28'b0, operand_b_o}, 32'd0);
        checkOutput("post_rst_last", {31'b0, last_o}, 32'd0);
      end
      if (prevHold) begin
        checkOutput("hold_a", {16'b0, operand_a_o}, {16'b0, prevA});
        checkOutput("hold_b", {28'b0, operand_b_o}, {28'b0, prevB});
        checkOutput("hold_last", {31'b0, last_o}, {31'b0, prevLast});
      end
      wHs = dWv && weight_ready_o;
      aHs = dAv && act_ready_o;
      oHs = out_valid_o && dOrdy;
      if (oHs) begin
        k = outCnt;
        if (k >= actQ.size() || (k / 8) >= wordQ.size()) begin
          checkOutput("spurious_pair", 32'd1, 32'd0);
        end else begin
          w = wordQ[k/8];
          checkOutput("pair_a", {16'b0, operand_a_o}, {16'b0, actQ[k]});
          checkOutput("pair_b", {28'b0, operand_b_o}, (w >> (4 * (k % 8))) & 32'hF);
          checkOutput("pair_last", {31'b0, last_o}, {31'b0, (k % 8) == 7});
        end
        outCnt++;
        outBs.push_back(operand_b_o);
        outCycles.push_back(cycleNo);
      end
      if (wHs) begin
        wordQ.push_back(dWord);
        wordHsCycle = cycleNo;
      end
      if (aHs) actQ.push_back(dAct);
      prevHold = out_valid_o && !dOrdy;
      prevA    = operand_a_o;
      prevB    = operand_b_o;
      prevLast = last_o;
    end
    justReset = 1'b0;
    lastWHs   = wHs;
    lastAHs   = aHs;
    @(posedge clk);
    if (!dRst) begin
      wordQ.delete();
      actQ.delete();
      outCnt    = 0;
      justReset = 1'b1;
    end
    cycleNo++;
  endtask

  task automatic resetDut();
    dRst  = 1'b0;
    dWv   = 1'b0;
    dAv   = 1'b0;
    dOrdy = 1'b0;
    applyStimulus();
    dRst = 1'b1;
  endtask

  // Feeds srcW/srcA with the given valid/ready percentages until drained.
  task automatic runTraffic(input int maxCycles, input int wP, input int aP, input int oP,
                            input int stallAt, input int stallLen);
    int n = 0;
    int stalled = 0;
    while (!(srcW.size() == 0 && srcA.size() == 0 && outCnt == actQ.size())) begin
      if (n >= maxCycles) begin
        checkOutput("traffic_timeout", n, maxCycles - 1);
        break;
      end
      dRst  = 1'b1;
      dWv   = (srcW.size() > 0) && ($urandom_range(99) < wP);
      dWord = dWv ? srcW[0] : $urandom;
      dAv   = (srcA.size() > 0) && ($urandom_range(99) < aP);
      dAct  = dAv ? srcA[0] : 16'($urandom);
      dOrdy = ($urandom_range(99) < oP);
      if (outCnt == stallAt && stalled < stallLen) begin
        dOrdy = 1'b0;
        stalled++;
      end
      applyStimulus();
      if (lastWHs) void'(srcW.pop_front());
      if (lastAHs) void'(srcA.pop_front());
      n++;
    end
  endtask

  initial begin
    rst_ni = 1'b0; weight_valid_i = 1'b0; weight_word_i = '0;
    act_valid_i = 1'b0; act_i = '0; out_ready_i = 1'b0;

    // Single word, eight activations, no backpressure.
    resetDut();
    resetDut();
    srcW = '{32'h76543210};
    for (int i = 0; i < 8; i++) srcA.push_back(16'h3C00 + 16'(i));
    outBs.delete();
    runTraffic(100, 100, 100, 100, -1, 0);
    checkOutput("t1_pairs", outBs.size(), 8);
    if (outBs.size() == 8) checkOutput("t1_b7", {28'b0, outBs[7]}, 32'd7);
    dWv = 1'b0; dAv = 1'b1; dOrdy = 1'b1;
    applyStimulus();
    checkOutput("t1_aready_idle", {31'b0, sAr}, 32'd0);
    checkOutput("t1_wready_idle", {31'b0, sWr}, 32'd1);

    // Back-to-back words: sixteen pairs with no boundary bubble.
    resetDut();
    srcW = '{32'h89ABCDEF, 32'h01234567};
    for (int i = 0; i < 16; i++) srcA.push_back(16'h4000 + 16'(i));
    outBs.delete(); outCycles.delete();
    runTraffic(100, 100, 100, 100, -1, 0);
    checkOutput("t2_pairs", outBs.size(), 16);
    if (outBs.size() == 16) begin
      checkOutput("t2_first_b", {28'b0, outBs[0]}, 32'hF);
      checkOutput("t2_b8", {28'b0, outBs[8]}, 32'h7);
      checkOutput("t2_span", outCycles[15] - outCycles[0], 15);
    end

    // Backpressure for three cycles while pair 2 is presented.
    resetDut();
    srcW = '{32'h76543210};
    for (int i = 0; i < 8; i++) srcA.push_back(16'h5000 + 16'(i));
    outBs.delete();
    runTraffic(100, 100, 100, 100, 1, 3);
    if (outBs.size() == 8) checkOutput("t3_pair3_b", {28'b0, outBs[2]}, 32'd2);
    else checkOutput("t3_pairs", outBs.size(), 8);

    // Activations with no word loaded, then the word arrives.
    resetDut();
    for (int i = 0; i < 5; i++) begin
      dWv = 1'b0; dAv = 1'b1; dAct = 16'h6000; dOrdy = 1'b1;
      applyStimulus();
    end
    srcW = '{32'hFEDCBA98};
    for (int i = 0; i < 8; i++) srcA.push_back(16'h6000 + 16'(i));
    outCycles.delete();
    runTraffic(100, 100, 100, 100, -1, 0);
    if (outCycles.size() > 0) checkOutput("t4_latency", outCycles[0] - wordHsCycle, 2);
    else checkOutput("t4_pairs", 0, 8);

    // Reset after three lanes, then a fresh word must start at its lane 0.
    resetDut();
    srcW = '{32'hFFFF8421};
    for (int i = 0; i < 3; i++) srcA.push_back(16'h7000 + 16'(i));
    runTraffic(100, 100, 100, 100, -1, 0);
    resetDut();
    srcW = '{32'h00000005};
    for (int i = 0; i < 8; i++) srcA.push_back(16'h7100 + 16'(i));
    outBs.delete();
    runTraffic(100, 100, 100, 100, -1, 0);
    if (outBs.size() > 0) checkOutput("t5_first_b", {28'b0, outBs[0]}, 32'd5);
    else checkOutput("t5_pairs", 0, 8);

    // Randomized valid/ready on all three interfaces over 1000 words.
    resetDut();
    for (int i = 0; i < 1000; i++) srcW.push_back($urandom);
    for (int i = 0; i < 8000; i++) srcA.push_back(16'($urandom));
    runTraffic(60000, 75, 80, 80, -1, 0);
    checkOutput("t6_pairs", outCnt, 8000);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/fp_int_operand_feeder.md
# fp_int_operand_feeder

Streaming operand feeder that sits directly upstream of the FP16×int mixed-precision multiplier. It accepts packed words of narrow signed-integer weights and a stream of FP16 activations, unpacks one weight lane per activation, and presents registered (activation, weight) operand pairs with a valid/ready handshake. It sustains one operand pair per cycle, including across weight-word boundaries.

## Interface
- `WIDTH_A`, 16: activation width (FP16 bit pattern).
- `INT_WIDTH`, 4: weight lane width (two's-complement integer bits, passed through raw).
- `WORD_WIDTH`, 32: packed weight word width; must be a multiple of `INT_WIDTH`.
- `LANES`, `WORD_WIDTH/INT_WIDTH` (8): derived, do not override.

Ports:
- `clk_i` input 1: clock, all state on rising edge.
- `rst_ni` input 1: synchronous, active-low reset.
- `weight_word_i` input `WORD_WIDTH`: packed weights; lane k = bits [k·INT_WIDTH +: INT_WIDTH], lane 0 consumed first.
- `weight_valid_i` input 1: weight word valid.
- `weight_ready_o` output 1: feeder can accept a word this cycle.
- `act_i` input `WIDTH_A`: FP16 activation.
- `act_valid_i` input 1: activation valid.
- `act_ready_o` output 1: activation consumed this cycle.
- `operand_a_o` output `WIDTH_A`: registered activation to multiplier.
- `operand_b_o` output `INT_WIDTH`: registered weight lane to multiplier.
- `last_o` output 1: registered; high when `operand_b_o` came from lane `LANES-1`.
- `out_valid_o` output 1: operand pair valid.
- `out_ready_i` input 1: downstream accepts the pair.

## Operation
- State: `EMPTY` (no word held) or `LOADED` (word held, lane index `idx` in 0..LANES-1 points at next lane).
- `can_issue` = `(!out_valid_o || out_ready_i)`.
- `fire` = `LOADED && act_valid_i && can_issue`; `act_ready_o` = `LOADED && can_issue`.
- On `fire`: `operand_a_o<=act_i`, `operand_b_o<=word[idx]`, `last_o<=(idx==LANES-1)`, `out_valid_o<=1`; if `idx<LANES-1` then `idx<=idx+1`, else the lane stream for the word is exhausted.
- Without `fire`: if `out_ready_i`, `out_valid_o<=0`. Operand/last registers hold their values.
- `weight_ready_o` = `rst_ni && (EMPTY || (LOADED && idx==LANES-1 && fire))`; combinational, allows a zero-bubble refill.
- Word accept (`weight_valid_i && weight_ready_o`): `word<=weight_word_i`, `idx<=0`, state `LOADED`.
- Last lane fires with no word accepted: state `EMPTY`, `idx<=0`.
- Simultaneous last-lane fire and word accept: the new word is loaded and the state stays `LOADED`. The old last lane is emitted this cycle, and the new lane 0 becomes available next cycle.
- No arithmetic or sign extension is done: lanes are passed bit-exact, and `act_i` is passed bit-exact (no NaN/denormal handling).
- `act_ready_o` is low in `EMPTY`; activations are never dropped or duplicated.
- Output is stable while `out_valid_o && !out_ready_i`; `act_ready_o` is low in that condition.

## Timing
- Reset (`rst_ni` low at edge): state `EMPTY`, `idx=0`, `word=0`, `out_valid_o=0`, `operand_a_o=0`, `operand_b_o=0`, `last_o=0`.
- `weight_ready_o` and `act_ready_o` are 0 while `rst_ni` is low.
- Reset mid-word discards the held word, remaining lanes and any pending output; no partial state survives.
- Latency: 1 cycle from `fire` to `out_valid_o`.
- Latency from word accept to the earliest lane-0 fire: 1 cycle, because the word registers first.
- Throughput: 1 pair/cycle sustained when `act_valid_i`, `out_ready_i` and `weight_valid_i` are held high. There are no bubbles at word boundaries after the first word.
- No combinational path from `act_i`/`weight_word_i` to outputs; `act_ready_o` depends on `out_ready_i` combinationally.

## Test plan
- Reset, then word 0x76543210 with 8 activations 0x3C00..0x3C07 and `out_ready_i`=1 -> 8 consecutive pairs with b=0..7 and a=0x3C00..0x3C07; `last_o` is high only on the 8th pair; then `act_ready_o`=0 and `weight_ready_o`=1.
- Back-to-back words 0x89ABCDEF, 0x01234567 with activations and `weight_valid_i` held high -> 16 pairs on 16 consecutive cycles: b=F,E,D,…,8, then 7,6,…,0; `weight_ready_o` pulses with the 8th lane fire.
- Backpressure: `out_ready_i` low for 3 cycles after pair 2 -> pair 2 is held stable, `act_ready_o`=0, no lane skipped; resumes with pair 3 (b=lane 2).
- Activations arrive with no word loaded (5 cycles `act_valid_i`=1) -> `act_ready_o`=0 and `out_valid_o`=0 throughout; the first pair appears 2 cycles after the word handshake.
- Reset asserted after 3 lanes of 0xFFFF8421 are issued -> all outputs 0 next cycle. A new word 0x00000005 then yields first pair b=5, not a leftover lane.
- Randomised valid/ready on all three interfaces over 1000 words -> the scoreboard shows an exact in-order pairing of activation j with lane j mod 8 of word j/8.
